mm_result_drain: RTL and testbench

Downstream stage of the unary matrix multiplier. Snapshots the DIM×DIM product matrix when the multiplier's `finished` level rises, then streams it out one element per handshake in row-major order over a valid/ready interface. Decouples the multiplier's accumulate array from slow consumers such as a bus writer or UART framer. Flags capture requests it cannot accept.

---
 rtl/mm_pkg.sv | 15 +
 rtl/mm_result_drain_rise_detect.sv | 19 +
 rtl/mm_result_drain.sv | 99 +++++++++
 tb/tb_mm_result_drain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types for the unary matrix multiplier slice.
package mm_pkg;

  localparam int MM_DIM   = 4;
  localparam int MM_WIDTH = 4;

  typedef logic [2*MM_WIDTH-1:0]     mm_elem_t;
  typedef logic [$clog2(MM_DIM)-1:0] mm_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

endpackage

// File: rtl/mm_result_drain_rise_detect.sv
// Registers a level and flags its 0->1 transition; reusable for any handshake edge.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= 1'b0;
    else          r_q <= i_level;
  end

  // r_q clears in reset, so a level held high through reset rises on the first edge.
  always_comb o_rise = i_level & ~r_q;

endmodule

// File: rtl/mm_result_drain.sv
// Snapshots the product matrix on a finished rise and streams it row-major over valid/ready.
module mm_result_drain
  import mm_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DIM-1:0][DIM-1:0][2*WIDTH-1:0] result,
  input  logic                                 finished,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [2*WIDTH-1:0]                   m_data,
  output logic [$clog2(DIM)-1:0]               m_row,
  output logic [$clog2(DIM)-1:0]               m_col,
  output logic                                 m_last,
  output logic                                 busy,
  output logic                                 overrun,
  input  logic                                 clr_overrun
);

  localparam int IW = $clog2(DIM);
  typedef logic [2*WIDTH-1:0] elem_t;
  typedef logic [IW-1:0]      idx_t;
  localparam idx_t IDX_MAX = idx_t'(DIM - 1);

  drain_state_e               r_state, w_next;
  elem_t [DIM-1:0][DIM-1:0]   r_snap;
  idx_t                       r_row, r_col;
  logic                       r_overrun;
  logic                       w_req, w_hs, w_at_last, w_load, w_adv, w_drop;

  rise_detect u_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (finished),
    .o_rise  (w_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = STREAM;
      STREAM:  if (w_hs && w_at_last && !w_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_hs      = m_valid & m_ready;
    w_at_last = (r_row == IDX_MAX) && (r_col == IDX_MAX);
    // A request landing on the last handshake reloads seamlessly rather than overrunning.
    w_load    = w_req & ((r_state == IDLE) | (w_hs & w_at_last));
    w_drop    = w_req & (r_state == STREAM) & ~(w_hs & w_at_last);
    w_adv     = w_hs & ~w_at_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_load) begin
      r_snap <= result;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_adv) begin
      if (r_col == IDX_MAX) begin
        r_col <= '0;
        r_row <= r_row + IW'(1);
      end else begin
        r_col <= r_col + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  always_comb begin
    m_valid = (r_state == STREAM);
    busy    = m_valid;
    m_data  = r_snap[r_row][r_col];
    m_row   = r_row;
    m_col   = r_col;
    m_last  = w_at_last && m_valid;
    overrun = r_overrun;
  end

endmodule

// File: tb/tb_mm_result_drain.sv
// Directed bench for mm_result_drain with DIM=4, WIDTH=4.
module tb_mm_result_drain;

  localparam int DIM   = 4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic finished = 1'b0;
  logic m_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic [DIM-1:0][DIM-1:0][2*WIDTH-1:0] result = '0;
  logic m_valid, m_last, busy, overrun;
  logic [2*WIDTH-1:0] m_data;
  logic [1:0] m_row, m_col;

  int n_vec = 0;
  int n_err = 0;

  mm_result_drain #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .result      (result),
    .finished    (finished),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_last      (m_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  // Hand-chosen matrices: p0 = 16*i+j, p1 = p0 with [1][2] = -3, p2 = 0x80+p0, p3 = 0xC0+p0.
  function automatic logic [7:0] pat(input int p, input int i, input int j);
    case (p)
      1:       pat = (i == 1 && j == 2) ? 8'hFD : 8'(16*i + j);
      2:       pat = 8'(8'h80 + 16*i + j);
      3:       pat = 8'(8'hC0 + 16*i + j);
      default: pat = 8'(16*i + j);
    endcase
  endfunction

  task automatic set_result(input int p);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        result[i][j] = pat(p, i, j);
  endtask

  task automatic test_reset;
    logic [13:0] exp_v;
    reset_n = 1'b0; finished = 1'b1; m_ready = 1'b1; set_result(0);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m_valid, busy, m_last, overrun, m_data, m_row, m_col} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_values: got %h want 0000",
               {m_valid, busy, m_last, overrun, m_data, m_row, m_col});
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, pat(0, k/4, k%4), 2'(k/4), 2'(k%4), (k == 15)};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL reset_stream[%0d]: got %h want %h", k,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({m_valid, busy, m_last} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_stream_end: got %b want 000", {m_valid, busy, m_last});
    end
    finished = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [13:0] exp_v;
    int k, cyc;
    finished = 1'b0; m_ready = 1'b0; set_result(1);
    @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 300) begin
      exp_v = {1'b1, pat(1, k/4, k%4), 2'(k/4), 2'(k%4), (k == 15)};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL bp_elem[%0d] cyc %0d: got %h want %h", k, cyc,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      m_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (m_ready) k++;
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (k !== 16) begin
      n_err++;
      $display("FAIL bp_handshakes: got %0d want 16 (cycle budget)", k);
    end
    m_ready = 1'b1;
    repeat (2) begin
      n_vec++;
      if (m_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_extra_valid: got %b want 0", m_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_isolation;
    logic [13:0] exp_v;
    finished = 1'b0; m_ready = 1'b1; set_result(2);
    @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    result = '1;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, pat(2, k/4, k%4), 2'(k/4), 2'(k%4), (k == 15)};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL iso_elem[%0d]: got %h want %h", k,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      @(negedge clk);
    end
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL iso_end_valid: got %b want 0", m_valid);
    end
  endtask

  task automatic test_overrun;
    logic [13:0] exp_v;
    int cyc;
    finished = 1'b0; m_ready = 1'b1; set_result(0);
    @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, pat(0, k/4, k%4), 2'(k/4), 2'(k%4), (k == 15)};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL ovr_elem[%0d]: got %h want %h", k,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      if (k == 5) begin finished = 1'b1; set_result(3); end
      if (k == 6) begin
        finished = 1'b0;
        n_vec++;
        if (overrun !== 1'b1) begin
          n_err++;
          $display("FAIL ovr_set: got %b want 1", overrun);
        end
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m_valid, overrun} !== 2'b01) begin
      n_err++;
      $display("FAIL ovr_sticky: got valid,overrun=%b want 01", {m_valid, overrun});
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
    // Drop and clear in the same cycle: set must win.
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    @(negedge clk);
    finished = 1'b1; clr_overrun = 1'b1;
    @(negedge clk);
    finished = 1'b0; clr_overrun = 1'b0;
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set_beats_clr: got %b want 1", overrun);
    end
    cyc = 0;
    while (m_valid === 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_drain: got valid %b want 0 (cycle budget)", m_valid);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear2: got %b want 0", overrun);
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] exp_v;
    int e;
    finished = 1'b0; m_ready = 1'b1; set_result(0);
    @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    for (int k = 0; k < 32; k++) begin
      e = k % 16;
      exp_v = {1'b1, pat((k < 16) ? 0 : 3, e/4, e%4), 2'(e/4), 2'(e%4), (e == 15)};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_elem[%0d]: got %h want %h", k,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      if (k == 15) begin finished = 1'b1; set_result(3); end
      if (k == 16) finished = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if ({m_valid, overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_end: got valid,overrun=%b want 00", {m_valid, overrun});
    end
  endtask

  task automatic test_reset_mid_stream;
    logic [13:0] exp_v;
    finished = 1'b0; m_ready = 1'b1; set_result(2);
    @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_v = {1'b1, pat(2, k/4, k%4), 2'(k/4), 2'(k%4), 1'b0};
      n_vec++;
      if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
        n_err++;
        $display("FAIL rst_mid_elem[%0d]: got %h want %h", k,
                 {m_valid, m_data, m_row, m_col, m_last}, exp_v);
      end
      if (k < 7) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({m_valid, busy, m_last, m_data} !== 11'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got %h want 000", {m_valid, busy, m_last, m_data});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if (m_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_no_resume: got %b want 0", m_valid);
      end
    end
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    exp_v = {1'b1, pat(2, 0, 0), 2'd0, 2'd0, 1'b0};
    n_vec++;
    if ({m_valid, m_data, m_row, m_col, m_last} !== exp_v) begin
      n_err++;
      $display("FAIL rst_mid_restart: got %h want %h",
               {m_valid, m_data, m_row, m_col, m_last}, exp_v);
    end
    repeat (17) @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_final: got %b want 0", m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_isolation();
    test_overrun();
    test_back_to_back();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
